// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns EX/MEM load/store requests into req/ack data-memory
// beats (scalar or four-beat 128-bit matrix), stalls upstream, and returns load results.
module mem_access_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  me_alu_o,
  input  logic [31:0]  me_regs_data2,
  input  logic [127:0] me_matrix_o,
  input  logic [4:0]   me_rd,
  input  logic         me_mem_read,
  input  logic         me_mem_write,
  input  logic         me_mem2reg,
  input  logic [1:0]   me_w_select,
  input  logic [2:0]   me_func3_code,
  output logic         dm_req,
  output logic         dm_we,
  output logic [31:0]  dm_addr,
  output logic [31:0]  dm_wdata,
  output logic [3:0]   dm_wstrb,
  input  logic         dm_ack,
  input  logic [31:0]  dm_rdata,
  output logic         stall_o,
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [31:0]  wb_data,
  output logic [127:0] wb_matrix,
  output logic         wb_mem2reg,
  output logic         err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  beat;
  logic        is_matrix_p1;
  logic        is_load_p1;
  logic        mem2reg_p1;
  logic [2:0]  func3_p1;
  logic [1:0]  off_p1;
  logic [4:0]  rd_p1;
  logic [95:0] mat_p1;

  logic op;
  logic is_matrix_in;
  logic legal;

  function automatic logic access_ok(input logic rd_en, input logic wr_en, input logic mat,
                                     input logic [2:0] f3, input logic [3:0] a);
    logic ok;
    if (rd_en && wr_en) ok = 1'b0;
    else if (mat) ok = (a == 4'd0);
    else begin
      case (f3)
        3'b000:  ok = 1'b1;
        3'b001:  ok = !a[0];
        3'b010:  ok = (a[1:0] == 2'd0);
        3'b100:  ok = rd_en;
        3'b101:  ok = rd_en && !a[0];
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    case (sz)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Byte/halfword lane select followed by sign or zero extension (func3[2] = unsigned).
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'd0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign op           = me_mem_read | me_mem_write;
  assign is_matrix_in = (me_w_select == 2'b01);
  assign legal        = access_ok(me_mem_read, me_mem_write, is_matrix_in, me_func3_code,
                                  me_alu_o[3:0]);
  assign stall_o      = (state == REQ) | ((state == IDLE) & op);

  // Control and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      beat       <= 2'd0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= 32'd0;
      dm_wdata   <= 32'd0;
      dm_wstrb   <= 4'd0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      wb_matrix  <= 128'd0;
      wb_mem2reg <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (op) begin
            if (!legal) begin
              state <= DONE;
              err_o <= 1'b1;
            end else begin
              state    <= REQ;
              beat     <= 2'd0;
              dm_req   <= 1'b1;
              dm_we    <= me_mem_write;
              dm_addr  <= {me_alu_o[31:2], 2'b00};
              dm_wdata <= is_matrix_in ? me_matrix_o[31:0]
                                       : store_data(me_func3_code[1:0], me_regs_data2);
              dm_wstrb <= me_mem_read ? 4'b0000
                        : (is_matrix_in ? 4'b1111
                                        : store_strb(me_func3_code[1:0], me_alu_o[1:0]));
            end
          end
        end
        REQ: begin
          if (dm_ack) begin
            if (is_matrix_p1 && (beat != 2'd3)) begin
              beat     <= beat + 2'd1;
              dm_addr  <= dm_addr + 32'd4;
              dm_wdata <= mat_p1[31:0];
            end else begin
              dm_req <= 1'b0;
              state  <= DONE;
              if (is_load_p1) begin
                wb_valid   <= 1'b1;
                wb_rd      <= rd_p1;
                wb_mem2reg <= mem2reg_p1;
                if (is_matrix_p1) wb_matrix <= {dm_rdata, mat_p1};
                else              wb_data   <= load_extract(func3_p1, off_p1, dm_rdata);
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Latched request fields; mat_p1 shifts out store words and shifts in load words
  always_ff @(posedge clk) begin
    if ((state == IDLE) && op) begin
      is_matrix_p1 <= is_matrix_in;
      is_load_p1   <= me_mem_read;
      mem2reg_p1   <= me_mem2reg;
      func3_p1     <= me_func3_code;
      off_p1       <= me_alu_o[1:0];
      rd_p1        <= me_rd;
      mat_p1       <= me_matrix_o[127:32];
    end else if ((state == REQ) && dm_ack) begin
      mat_p1 <= {dm_rdata, mat_p1[95:32]};
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores, a memory responder with
// programmable ack delay, and a monitor that checks every beat, writeback and error pulse.
module tb_mem_access_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  me_alu_o = '0;
  logic [31:0]  me_regs_data2 = '0;
  logic [127:0] me_matrix_o = '0;
  logic [4:0]   me_rd = '0;
  logic         me_mem_read = 1'b0;
  logic         me_mem_write = 1'b0;
  logic         me_mem2reg = 1'b0;
  logic [1:0]   me_w_select = '0;
  logic [2:0]   me_func3_code = '0;
  logic         dm_req, dm_we;
  logic [31:0]  dm_addr, dm_wdata;
  logic [3:0]   dm_wstrb;
  logic         dm_ack = 1'b0;
  logic [31:0]  dm_rdata = '0;
  logic         stall_o, wb_valid, wb_mem2reg, err_o;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic [127:0] wb_matrix;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2),
    .me_matrix_o(me_matrix_o), .me_rd(me_rd), .me_mem_read(me_mem_read),
    .me_mem_write(me_mem_write), .me_mem2reg(me_mem2reg), .me_w_select(me_w_select),
    .me_func3_code(me_func3_code), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_o(stall_o), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_matrix(wb_matrix), .wb_mem2reg(wb_mem2reg), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  typedef struct {
    logic [4:0]   rd;
    logic         mat;
    logic [31:0]  data;
    logic [127:0] matrix;
  } wb_t;

  beat_t       exp_beats[$];
  wb_t         exp_wb[$];
  logic [31:0] rdata_q[$];
  int          err_pend = 0;
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          drove = 1'b0;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] st);
    beat_t b;
    b.addr = a; b.we = we; b.wdata = wd; b.wstrb = st;
    exp_beats.push_back(b);
  endtask

  task automatic exp_load(input logic [4:0] r, input logic m, input logic [31:0] d,
                          input logic [127:0] mx);
    wb_t w;
    w.rd = r; w.mat = m; w.data = d; w.matrix = mx;
    exp_wb.push_back(w);
  endtask

  // Memory responder: acks each beat after ack_delay low cycles
  always @(posedge clk) begin
    #1;
    if (drove) begin
      if (rdata_q.size() > 0) void'(rdata_q.pop_front());
      wait_cnt = 0;
    end
    drove = 1'b0;
    if (dm_req && rst) begin
      if (wait_cnt >= ack_delay) begin
        dm_ack   = 1'b1;
        dm_rdata = (rdata_q.size() > 0) ? rdata_q[0] : 32'd0;
        drove    = 1'b1;
      end else begin
        dm_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      dm_ack = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin : mon
    beat_t b;
    wb_t   w;
    if (dm_req) begin
      if (exp_beats.size() == 0) chk("unexpected_req", 128'(dm_req), 128'd0);
      else begin
        b = exp_beats[0];
        chk("beat_addr", 128'(dm_addr), 128'(b.addr));
        chk("beat_we", 128'(dm_we), 128'(b.we));
        chk("beat_wstrb", 128'(dm_wstrb), 128'(b.wstrb));
        if (b.we) chk("beat_wdata", 128'(dm_wdata), 128'(b.wdata));
        if (dm_ack) void'(exp_beats.pop_front());
      end
    end
    if (wb_valid) begin
      if (exp_wb.size() == 0) chk("unexpected_wb", 128'(wb_valid), 128'd0);
      else begin
        w = exp_wb.pop_front();
        chk("wb_rd", 128'(wb_rd), 128'(w.rd));
        chk("wb_mem2reg", 128'(wb_mem2reg), 128'd1);
        if (w.mat) chk("wb_matrix", wb_matrix, w.matrix);
        else       chk("wb_data", 128'(wb_data), 128'(w.data));
      end
    end
    if (err_o) begin
      if (err_pend == 0) chk("unexpected_err", 128'(err_o), 128'd0);
      else err_pend--;
    end
  end

  task automatic run_op(input string name, input logic rd_en, input logic wr_en,
                        input logic [1:0] wsel, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] d2, input logic [127:0] mat, input logic [4:0] rdn,
                        input int exp_stall);
    int cnt;
    @(negedge clk);
    me_mem_read   = rd_en;
    me_mem_write  = wr_en;
    me_w_select   = wsel;
    me_func3_code = f3;
    me_alu_o      = addr;
    me_regs_data2 = d2;
    me_matrix_o   = mat;
    me_rd         = rdn;
    me_mem2reg    = rd_en;
    #1;
    cnt = 0;
    while (stall_o && cnt < 50) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    me_mem_read  = 1'b0;
    me_mem_write = 1'b0;
    chk({name, "_stall"}, 128'(cnt), 128'(exp_stall));
    chk({name, "_pending"}, 128'(exp_beats.size() + exp_wb.size() + err_pend), 128'd0);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_req"}, 128'(dm_req), 128'd0);
    chk({n, "_we"}, 128'(dm_we), 128'd0);
    chk({n, "_addr"}, 128'(dm_addr), 128'd0);
    chk({n, "_wdata"}, 128'(dm_wdata), 128'd0);
    chk({n, "_wstrb"}, 128'(dm_wstrb), 128'd0);
    chk({n, "_stall"}, 128'(stall_o), 128'd0);
    chk({n, "_wbv"}, 128'(wb_valid), 128'd0);
    chk({n, "_wbrd"}, 128'(wb_rd), 128'd0);
    chk({n, "_wbdata"}, 128'(wb_data), 128'd0);
    chk({n, "_wbmat"}, wb_matrix, 128'd0);
    chk({n, "_m2r"}, 128'(wb_mem2reg), 128'd0);
    chk({n, "_err"}, 128'(err_o), 128'd0);
  endtask

  localparam logic [127:0] MAT_ST = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] MAT_RS = 128'h88888888_77777777_66666666_55555555;

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // LB with sign extension, ack immediate
    ack_delay = 0;
    rdata_q.push_back(32'h80FF_0000);
    exp_beat(32'h1000, 1'b0, 32'd0, 4'b0000);
    exp_load(5'd3, 1'b0, 32'hFFFF_FF80, 128'd0);
    run_op("lb", 1'b1, 1'b0, 2'b00, 3'b000, 32'h1003, 32'd0, 128'd0, 5'd3, 2);

    // SH upper half, ack delayed 3 cycles
    ack_delay = 3;
    exp_beat(32'h2000, 1'b1, 32'hBEEF_BEEF, 4'b1100);
    run_op("sh", 1'b0, 1'b1, 2'b00, 3'b001, 32'h2002, 32'h0000_BEEF, 128'd0, 5'd0, 5);

    // Matrix store
    ack_delay = 0;
    exp_beat(32'h100, 1'b1, 32'h1111_1111, 4'b1111);
    exp_beat(32'h104, 1'b1, 32'h2222_2222, 4'b1111);
    exp_beat(32'h108, 1'b1, 32'h3333_3333, 4'b1111);
    exp_beat(32'h10C, 1'b1, 32'h4444_4444, 4'b1111);
    run_op("mst", 1'b0, 1'b1, 2'b01, 3'b000, 32'h100, 32'd0, MAT_ST, 5'd0, 5);

    // Matrix load with ack toggling
    ack_delay = 1;
    rdata_q.push_back(32'hA); rdata_q.push_back(32'hB);
    rdata_q.push_back(32'hC); rdata_q.push_back(32'hD);
    exp_beat(32'h200, 1'b0, 32'd0, 4'b0000);
    exp_beat(32'h204, 1'b0, 32'd0, 4'b0000);
    exp_beat(32'h208, 1'b0, 32'd0, 4'b0000);
    exp_beat(32'h20C, 1'b0, 32'd0, 4'b0000);
    exp_load(5'd9, 1'b1, 32'd0, 128'h0000000D_0000000C_0000000B_0000000A);
    run_op("mld", 1'b1, 1'b0, 2'b01, 3'b000, 32'h200, 32'd0, 128'd0, 5'd9, 9);

    // Illegal accesses
    ack_delay = 0;
    err_pend++;
    run_op("ill_lw", 1'b1, 1'b0, 2'b00, 3'b010, 32'h2001, 32'd0, 128'd0, 5'd1, 1);
    err_pend++;
    run_op("ill_mld", 1'b1, 1'b0, 2'b01, 3'b000, 32'h108, 32'd0, 128'd0, 5'd1, 1);
    err_pend++;
    run_op("ill_rw", 1'b1, 1'b1, 2'b00, 3'b010, 32'h0, 32'd0, 128'd0, 5'd1, 1);
    err_pend++;
    run_op("ill_sf3", 1'b0, 1'b1, 2'b00, 3'b100, 32'h0, 32'd0, 128'd0, 5'd1, 1);

    // Other scalar widths and lanes
    rdata_q.push_back(32'h8001_1234);
    exp_beat(32'h2000, 1'b0, 32'd0, 4'b0000);
    exp_load(5'd4, 1'b0, 32'h0000_8001, 128'd0);
    run_op("lhu", 1'b1, 1'b0, 2'b00, 3'b101, 32'h2002, 32'd0, 128'd0, 5'd4, 2);

    rdata_q.push_back(32'h1234_F00D);
    exp_beat(32'h0, 1'b0, 32'd0, 4'b0000);
    exp_load(5'd5, 1'b0, 32'hFFFF_F00D, 128'd0);
    run_op("lh", 1'b1, 1'b0, 2'b00, 3'b001, 32'h0, 32'd0, 128'd0, 5'd5, 2);

    rdata_q.push_back(32'h80FF_0000);
    exp_beat(32'h1000, 1'b0, 32'd0, 4'b0000);
    exp_load(5'd6, 1'b0, 32'h0000_0080, 128'd0);
    run_op("lbu", 1'b1, 1'b0, 2'b00, 3'b100, 32'h1003, 32'd0, 128'd0, 5'd6, 2);

    exp_beat(32'h3000, 1'b1, 32'hABAB_ABAB, 4'b0010);
    run_op("sb", 1'b0, 1'b1, 2'b00, 3'b000, 32'h3001, 32'h0000_00AB, 128'd0, 5'd0, 2);

    ack_delay = 2;
    exp_beat(32'h40, 1'b1, 32'hDEAD_BEEF, 4'b1111);
    run_op("sw", 1'b0, 1'b1, 2'b00, 3'b010, 32'h40, 32'hDEAD_BEEF, 128'd0, 5'd0, 4);

    ack_delay = 0;
    rdata_q.push_back(32'hCAFE_BABE);
    exp_beat(32'h10, 1'b0, 32'd0, 4'b0000);
    exp_load(5'd31, 1'b0, 32'hCAFE_BABE, 128'd0);
    run_op("lw", 1'b1, 1'b0, 2'b00, 3'b010, 32'h10, 32'd0, 128'd0, 5'd31, 2);

    // Reset in the middle of a matrix store
    @(negedge clk);
    exp_beat(32'h300, 1'b1, 32'h5555_5555, 4'b1111);
    exp_beat(32'h304, 1'b1, 32'h6666_6666, 4'b1111);
    exp_beat(32'h308, 1'b1, 32'h7777_7777, 4'b1111);
    exp_beat(32'h30C, 1'b1, 32'h8888_8888, 4'b1111);
    me_mem_write = 1'b1; me_mem_read = 1'b0; me_w_select = 2'b01;
    me_alu_o = 32'h300; me_matrix_o = MAT_RS; me_func3_code = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    me_mem_write = 1'b0;
    @(negedge clk);
    #1;
    chk_zero("midrst");
    chk("midrst_left", 128'(exp_beats.size()), 128'd1);
    exp_beats.delete();
    rst = 1'b1;

    rdata_q.push_back(32'h1234_5678);
    exp_beat(32'h0, 1'b0, 32'd0, 4'b0000);
    exp_load(5'd2, 1'b0, 32'h1234_5678, 128'd0);
    run_op("lw_after_rst", 1'b1, 1'b0, 2'b00, 3'b010, 32'h0, 32'd0, 128'd0, 5'd2, 2);

    repeat (3) @(negedge clk);
    chk("end_rdata_left", 128'(rdata_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit that sits on the output side of the EX/MEM pipeline register. It turns the registered `me_*` control and data into data-memory transactions over a req/ack handshake: scalar loads and stores, plus 128-bit matrix loads and stores performed as four word beats. It stalls the upstream pipeline until each access completes, then presents load results to the MEM/WB stage.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `me_alu_o` in 32: effective byte address.
- `me_regs_data2` in 32: scalar store data.
- `me_matrix_o` in 128: matrix store data. Word i is `[32i+31:32i]`.
- `me_rd` in 5: load destination register.
- `me_mem_read` in 1: load request.
- `me_mem_write` in 1: store request.
- `me_mem2reg` in 1: passed to `wb_mem2reg`.
- `me_w_select` in 2: `2'b01` selects a matrix (128-bit) access; any other value selects a scalar access.
- `me_func3_code` in 3: RISC-V load/store width code.
- `dm_req` out 1: memory request.
- `dm_we` out 1: 1 = write.
- `dm_addr` out 32: word-aligned address.
- `dm_wdata` out 32: write data.
- `dm_wstrb` out 4: byte enables.
- `dm_ack` in 1: memory accepts the beat. On reads, `dm_rdata` is valid in the same cycle.
- `dm_rdata` in 32: read data.
- `stall_o` out 1: freezes the EX/MEM register and upstream stages.
- `wb_valid` out 1: one-cycle pulse when load data is ready.
- `wb_rd` out 5: destination register for the load.
- `wb_data` out 32: scalar load result.
- `wb_matrix` out 128: matrix load result.
- `wb_mem2reg` out 1: registered copy of `me_mem2reg`.
- `err_o` out 1: one-cycle pulse on an illegal access.

## Operation
States: IDLE, REQ, DONE.

- **IDLE.** If `me_mem_read | me_mem_write`, check legality.
  - Illegal: go to DONE, pulse `err_o`, no memory access, no `wb_valid`.
  - Legal: latch all inputs, set the beat counter to 0, drive the `dm_*` registers, go to REQ.
- **REQ.**
  - `dm_req` stays 1, and `dm_addr`, `dm_we`, `dm_wdata`, `dm_wstrb` stay stable until `dm_ack` is sampled high.
  - On ack of a non-final beat: the counter increments, `dm_addr` += 4, `dm_wdata` takes the next matrix word, and `dm_req` stays high.
  - On ack of the final beat: `dm_req` goes to 0 and the state goes to DONE.
- **DONE.** Lasts one cycle, then returns to IDLE. Inputs are ignored in DONE, so the completed instruction is never re-issued.
- **`stall_o`** (combinational):
  - 1 in REQ.
  - 1 in IDLE when `me_mem_read | me_mem_write`.
  - 0 otherwise, including in DONE.

Illegal access conditions:
- `me_mem_read` and `me_mem_write` both 1.
- Scalar func3 not in {000, 001, 010, 100, 101} for loads, or not in {000, 001, 010} for stores.
- Halfword access with `addr[0]` = 1.
- Word access with `addr[1:0]` ≠ 0.
- Matrix access with `addr[3:0]` ≠ 0. `func3` is ignored for matrix accesses.

Scalar addressing and stores:
- `dm_addr` = `{addr[31:2], 2'b00}`.
- Loads drive `dm_wstrb` = 0.
- SB: `wstrb` = `1 << addr[1:0]`; `wdata` = the byte replicated ×4.
- SH: `wstrb` = `addr[1] ? 4'b1100 : 4'b0011`; `wdata` = the halfword replicated ×2.
- SW: `wstrb` = 4'b1111.

Scalar loads:
- LB/LBU: select the byte at `addr[1:0]`, then sign- or zero-extend.
- LH/LHU: select the halfword at `addr[1]`, then sign- or zero-extend.
- LW: use the word directly.

Matrix accesses:
- Four beats at base, +4, +8, +12, each with `wstrb` = 4'b1111 on stores.
- On loads, beat i `dm_rdata` goes into `wb_matrix[32i+31:32i]`.

Results:
- `wb_data`, `wb_matrix`, `wb_rd` and `wb_mem2reg` update on the completing ack and hold until the next load completes.
- `wb_valid` is 1 during DONE for loads only.

## Timing
- Reset value of every output is 0, and the state goes to IDLE. A reset mid-transaction abandons it immediately: `dm_req` = 0 the next cycle, nothing is retried.
- Scalar access with `dm_ack` tied high:
  - cycle 0: IDLE, op seen, `stall_o` = 1.
  - cycle 1: REQ, ack.
  - cycle 2: DONE, `wb_valid`.
  - cycle 3: IDLE, next instruction.
  - Total stall is 2 cycles.
- Matrix access with ack high: beats in cycles 1–4, DONE in cycle 5. Total stall is 5 cycles.
- Each cycle that `dm_ack` is low in REQ adds one stall cycle.
- Illegal access: `err_o` and DONE follow 1 cycle after the op is seen.
- The upstream pipeline holds all `me_*` inputs stable while `stall_o` = 1.

## Test plan
- **Reset then LB:** `addr`=0x1003, `rdata`=0x80FF_0000, ack high → `wb_data`=0xFFFF_FF80, `wb_valid` in cycle 2, `stall_o` high in cycles 0–1.
- **SH with ack delayed 3 cycles:** `addr`=0x2002, `data2`=0x0000_BEEF → `dm_addr`=0x2000, `wstrb`=1100, `wdata`=0xBEEF_BEEF held 4 cycles; no `wb_valid`.
- **Matrix store:** `addr`=0x100, `matrix`=0x44..33..22..11 (words 0x11111111 to 0x44444444) → beats at 0x100/104/108/10C carrying words 0–3 in order.
- **Matrix load with ack toggling:** read data 0xA, 0xB, 0xC, 0xD → `wb_matrix`={D,C,B,A}, one `wb_valid` pulse.
- **Illegal accesses:** LW at 0x2001 → `err_o` pulse, `dm_req` never asserted. Matrix load at 0x108 → `err_o`. Read and write both high → `err_o`.
- **Reset mid-matrix:** reset asserted after beat 1 ack → all outputs 0 the next cycle; a following LW at 0x0 completes normally.
